// File: rtl/sint_req_arb.sv
// rtl/sint_req_arb.sv - weighted round-robin arbiter feeding scene intersection
// Two 2-entry skid FIFOs feed a registered output stage; the winner is picked by burst-limited round robin.
module sint_req_arb #(
    parameter int WIDTH = 64,
    parameter int W0    = 1,
    parameter int W1    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             us0_valid,
    input  logic [WIDTH-1:0] us0_data,
    output logic             us0_stall,
    input  logic             us1_valid,
    input  logic [WIDTH-1:0] us1_data,
    output logic             us1_stall,
    output logic             ds_valid,
    output logic [WIDTH-1:0] ds_data,
    output logic             ds_src,
    input  logic             ds_stall,
    output logic [1:0]       occ0,
    output logic [1:0]       occ1
);

    localparam logic [3:0] W0_L = 4'(W0);
    localparam logic [3:0] W1_L = 4'(W1);

    logic [WIDTH-1:0] mem_q [2][2];
    logic [WIDTH-1:0] mem_d [2][2];
    logic [1:0]       rd_q, rd_d;
    logic [1:0]       occ_q [2];
    logic [1:0]       occ_d [2];

    logic             ds_valid_q, ds_valid_d;
    logic [WIDTH-1:0] ds_data_q, ds_data_d;
    logic             ds_src_q, ds_src_d;
    logic             cur_q, cur_d;
    logic [3:0]       burst_q, burst_d;

    logic [1:0]       us_valid;
    logic [WIDTH-1:0] us_data [2];
    logic [1:0]       full;
    logic [1:0]       nonempty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             load;
    logic             grant;
    logic [3:0]       w_cur;

    assign us_valid   = {us1_valid, us0_valid};
    assign us_data[0] = us0_data;
    assign us_data[1] = us1_data;

    // Backpressure comes only from registered occupancy, never from ds_stall.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            full[n]     = (occ_q[n] == 2'd2);
            nonempty[n] = (occ_q[n] != 2'd0);
            push[n]     = us_valid[n] & ~full[n];
        end
    end

    always_comb begin
        w_cur = cur_q ? W1_L : W0_L;
        load  = en & (~ds_valid_q | ~ds_stall) & (nonempty[0] | nonempty[1]);
        if (nonempty[0] & nonempty[1]) begin
            grant = (burst_q < w_cur) ? cur_q : ~cur_q;
        end else begin
            grant = nonempty[1];
        end
        pop = 2'b00;
        if (load) begin
            pop[grant] = 1'b1;
        end
    end

    // Write slot is head when empty and the other slot when one word is held.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_d[n][rd_q[n] ^ occ_q[n][0]] = us_data[n];
            end
            if (pop[n]) begin
                rd_d[n] = ~rd_q[n];
            end
            case ({push[n], pop[n]})
                2'b10:   occ_d[n] = occ_q[n] + 2'd1;
                2'b01:   occ_d[n] = occ_q[n] - 2'd1;
                default: occ_d[n] = occ_q[n];
            endcase
        end
    end

    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_data_d  = ds_data_q;
        ds_src_d   = ds_src_q;
        cur_d      = cur_q;
        burst_d    = burst_q;
        if (load) begin
            ds_valid_d = 1'b1;
            ds_data_d  = mem_q[grant][rd_q[grant]];
            ds_src_d   = grant;
            if (grant == cur_q) begin
                burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
            end else begin
                cur_d   = grant;
                burst_d = 4'd1;
            end
        end else if (ds_valid_q & ~ds_stall) begin
            ds_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q       <= 2'b00;
            occ_q[0]   <= 2'd0;
            occ_q[1]   <= 2'd0;
            ds_valid_q <= 1'b0;
            ds_data_q  <= '0;
            ds_src_q   <= 1'b0;
            cur_q      <= 1'b0;
            burst_q    <= 4'd0;
        end else begin
            rd_q       <= rd_d;
            occ_q      <= occ_d;
            ds_valid_q <= ds_valid_d;
            ds_data_q  <= ds_data_d;
            ds_src_q   <= ds_src_d;
            cur_q      <= cur_d;
            burst_q    <= burst_d;
        end
    end

    assign us0_stall = full[0];
    assign us1_stall = full[1];
    assign occ0      = occ_q[0];
    assign occ1      = occ_q[1];
    assign ds_valid  = ds_valid_q;
    assign ds_data   = ds_data_q;
    assign ds_src    = ds_src_q;

endmodule
